// File: rtl/usr_pkg.sv
// Shared types and constants for the parameterised shift register.
package usr_pkg;

    localparam int unsigned UsrDefaultWidth = 8;

    typedef enum logic [2:0] {
        ModeHold = 3'b000,
        ModeShr  = 3'b001,
        ModeShl  = 3'b010,
        ModeLoad = 3'b011,
        ModeAsr  = 3'b100,
        ModeRor  = 3'b101,
        ModeRol  = 3'b110,
        ModeClr  = 3'b111
    } usr_mode_e;

    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } usr_state_e;

    function automatic logic is_rotate(input usr_mode_e m);
        return (m == ModeRor) || (m == ModeRol);
    endfunction

    // Modes whose amt field sets the number of steps.
    function automatic logic is_stepped(input usr_mode_e m);
        return (m == ModeShr) || (m == ModeShl) || (m == ModeAsr) || is_rotate(m);
    endfunction

endpackage

// File: rtl/usr_step_unit.sv
// Combinational single-step datapath: one shift, rotate or clear of the register.
// ROR/ROL paths exist only when USR_ROTATE_EN is defined.
module usr_step_unit
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = UsrDefaultWidth
) (
    input  logic [WIDTH-1:0] data,
    input  usr_mode_e        mode,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] next_data
);

    always_comb begin
        next_data = data;
        unique case (mode)
            ModeShr: next_data = {ser_in_l, data[WIDTH-1:1]};
            ModeShl: next_data = {data[WIDTH-2:0], ser_in_r};
            ModeAsr: next_data = {data[WIDTH-1], data[WIDTH-1:1]};
`ifdef USR_ROTATE_EN
            ModeRor: next_data = {data[0], data[WIDTH-1:1]};
            ModeRol: next_data = {data[WIDTH-2:0], data[WIDTH-1]};
`endif
            ModeClr: next_data = '0;
            default: next_data = data;
        endcase
    end

endmodule

// File: rtl/param_shift_reg.sv
// Parameterised shift/rotate register with a command interface and multi-step FSM.
// Define USR_ROTATE_EN to enable ROR/ROL; without it those modes pulse cmd_err.
module param_shift_reg
    import usr_pkg::*;
#(
    parameter int unsigned WIDTH = UsrDefaultWidth,
    localparam int unsigned AMT_W = $clog2(WIDTH) + 1
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       mode,
    input  logic [AMT_W-1:0] amt,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ser_in_l,
    input  logic             ser_in_r,
    output logic [WIDTH-1:0] data_out,
    output logic             busy,
    output logic             done,
    output logic             cmd_err
);

    usr_state_e       state_q, state_d;
    usr_mode_e        mode_q, mode_d, cmd_mode, step_mode;
    logic [AMT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d, step_data;
    logic             done_q, done_d, err_q, err_d;
    logic             accept;

    assign cmd_mode  = usr_mode_e'(mode);
    assign accept    = cmd_valid && (state_q == StIdle);
    assign step_mode = (state_q == StRun) ? mode_q : cmd_mode;

    usr_step_unit #(
        .WIDTH(WIDTH)
    ) u_step (
        .data     (data_q),
        .mode     (step_mode),
        .ser_in_l (ser_in_l),
        .ser_in_r (ser_in_r),
        .next_data(step_data)
    );

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mode_d = cmd_mode;
                    if (cmd_mode == ModeLoad) begin
                        data_d = data_in;
                        done_d = 1'b1;
                    end else if (!is_stepped(cmd_mode)) begin
                        data_d = step_data;
                        done_d = 1'b1;
`ifndef USR_ROTATE_EN
                    end else if (is_rotate(cmd_mode)) begin
                        err_d = 1'b1;
`endif
                    end else if (amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        // First step happens on the accept edge; RUN covers the rest.
                        data_d = step_data;
                        if (amt == AMT_W'(1)) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = StRun;
                            cnt_d   = amt - AMT_W'(1);
                        end
                    end
                end
            end
            StRun: begin
                data_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
                if (cnt_q == AMT_W'(1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            mode_q  <= ModeHold;
            cnt_q   <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign data_out  = data_q;
    assign busy      = (state_q == StRun);
    assign cmd_ready = !busy;
    assign done      = done_q;
    assign cmd_err   = err_q;

endmodule
